// File: rtl/uart_echo_tester.sv
// UART loopback tester: sends an LFSR pattern frame, then checks the echo.
// Reports pass, mismatch count and receive timeout once the frame ends.
module uart_echo_tester #(
  parameter int unsigned FRAME_LEN      = 256,
  parameter logic [7:0]  SEED           = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic        timeout
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  // An all-zero seed would lock the LFSR at zero.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    tx_lfsr_q, tx_lfsr_d;
  logic [7:0]    rx_lfsr_q, rx_lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [TW-1:0] to_nxt;
  logic [15:0]   err_q, err_d;
  logic          timeout_q, timeout_d;
  logic          pass_q, pass_d;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  always_comb begin
    state_d   = state_q;
    tx_lfsr_d = tx_lfsr_q;
    rx_lfsr_d = rx_lfsr_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    to_nxt    = to_q + 1'b1;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SEND;
          tx_lfsr_d = SEED_EFF;
          rx_lfsr_d = SEED_EFF;
          cnt_d     = '0;
          to_d      = '0;
          err_d     = '0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_lfsr_d = lfsr_step(tx_lfsr_q);
          if (cnt_q == LAST) begin
            state_d = RECV;
            cnt_d   = '0;
            to_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RECV: begin
        // A byte on the timeout edge still counts and restarts the timer.
        if (rx_valid) begin
          rx_lfsr_d = lfsr_step(rx_lfsr_q);
          to_d      = '0;
          if (rx_data != rx_lfsr_q && err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            pass_d  = (err_d == 16'd0);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          to_d = to_nxt;
          if (to_nxt == TMAX) begin
            state_d   = DONE;
            timeout_d = 1'b1;
            pass_d    = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_lfsr_q <= SEED_EFF;
      rx_lfsr_q <= SEED_EFF;
      cnt_q     <= '0;
      to_q      <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_lfsr_q <= tx_lfsr_d;
      rx_lfsr_q <= rx_lfsr_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
    end
  end

  assign tx_data   = tx_lfsr_q;
  assign tx_valid  = (state_q == SEND);
  assign rx_ready  = (state_q == RECV);
  assign busy      = (state_q == SEND) || (state_q == RECV);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign timeout   = timeout_q;

endmodule
